// File: rtl/sara_pkg.sv
// Shared definitions for the SARA reconfiguration controller: FSM encoding,
// derived widths and the level-to-ApproxRCON mapping.
package sara_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DECIDE = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // Window error accumulator width: one sample error is SIZE+1 bits wide and
  // a window sums WINDOW of them.
  function automatic int acc_width(int size, int window);
    return size + 1 + $clog2(window);
  endfunction

  // Width needed to hold levels 0..ng inclusive.
  function automatic int lvl_width(int ng);
    return (ng < 1) ? 1 : $clog2(ng + 1);
  endfunction

  // Group k (0-indexed) is approximate (0) for the lowest 'level' groups and
  // passes the exact carry (1) above them.
  function automatic logic rcon_bit(int level, int k);
    return (k >= level);
  endfunction

endpackage

// File: rtl/sara_err_calc.sv
// Combinational error of one SARA adder result against the exact sum:
// |A + B + CIN - {COUT_APX, SUM_APX}|.
module sara_err_calc #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_cin,
  input  logic [SIZE-1:0] i_sum_apx,
  input  logic            i_cout_apx,
  output logic [SIZE:0]   o_err
);

  logic [SIZE:0] w_exact;
  logic [SIZE:0] w_apx;

  assign w_exact = {1'b0, i_a} + {1'b0, i_b} + {{SIZE{1'b0}}, i_cin};
  assign w_apx   = {i_cout_apx, i_sum_apx};
  assign o_err   = (w_exact >= w_apx) ? (w_exact - w_apx) : (w_apx - w_exact);

endmodule

// File: rtl/sara_recon_ctrl.sv
// Window-based approximation controller for a SARA adder: sums the adder's
// error over WINDOW accepted samples and relaxes or tightens ApproxRCON.
module sara_recon_ctrl
  import sara_pkg::*;
#(
  parameter int  SIZE      = 16,
  parameter int  GROUPSIZE = 8,
  parameter int  WINDOW    = 16,
  parameter int  ACCW      = acc_width(SIZE, WINDOW),
  localparam int NG        = SIZE / GROUPSIZE,
  localparam int LVLW      = lvl_width(NG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            CIN,
  input  logic [SIZE-1:0] SUM_APX,
  input  logic            COUT_APX,
  input  logic            ENABLE,
  input  logic            FORCE_EXACT,
  input  logic [ACCW-1:0] THRESH,
  output logic [NG-1:0]   ApproxRCON,
  output logic [LVLW-1:0] LEVEL,
  output logic [ACCW-1:0] ERR_ACC,
  output logic            WIN_DONE
);

  localparam int CNTW = $clog2(WINDOW);
  localparam int ERRW = SIZE + 1;

  state_e          r_state;
  state_e          w_next;
  logic [ACCW-1:0] r_acc;
  logic [ACCW-1:0] r_err_acc;
  logic [CNTW-1:0] r_cnt;
  logic [LVLW-1:0] r_level;
  logic [NG-1:0]   r_rcon;
  logic            r_win_done;

  logic [ERRW-1:0] w_err;
  logic [ACCW:0]   w_acc_sum;
  logic [ACCW-1:0] w_acc_next;
  logic            w_ready;
  logic            w_accept;
  logic            w_last;
  logic [LVLW-1:0] w_level_next;
  logic [NG-1:0]   w_rcon_next;

  sara_err_calc #(
    .SIZE (SIZE)
  ) u_err_calc (
    .i_a        (A),
    .i_b        (B),
    .i_cin      (CIN),
    .i_sum_apx  (SUM_APX),
    .i_cout_apx (COUT_APX),
    .o_err      (w_err)
  );

  // Saturating add: the carry out of the widened sum clamps to all ones.
  assign w_acc_sum  = {1'b0, r_acc} + (ACCW + 1)'(w_err);
  assign w_acc_next = w_acc_sum[ACCW] ? '1 : w_acc_sum[ACCW-1:0];
  assign w_accept   = IN_VALID && w_ready;
  assign w_last     = (r_cnt == CNTW'(WINDOW - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_SETTLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (FORCE_EXACT) begin
      w_next = ST_SETTLE;
    end else begin
      case (r_state)
        ST_ACCUM:  if (w_accept && w_last) w_next = ST_DECIDE;
        ST_DECIDE: w_next = (w_level_next != r_level) ? ST_SETTLE : ST_ACCUM;
        ST_SETTLE: w_next = ST_ACCUM;
        default:   w_next = ST_SETTLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_ready      = 1'b0;
    w_level_next = r_level;
    w_rcon_next  = '1;
    if (!RST && !FORCE_EXACT && (r_state == ST_ACCUM)) w_ready = 1'b1;
    if (FORCE_EXACT) begin
      w_level_next = '0;
    end else if (r_state == ST_DECIDE) begin
      if (ENABLE && (r_acc > THRESH) && (r_level != '0))
        w_level_next = r_level - 1'b1;
      else if (ENABLE && (r_acc < (THRESH >> 2)) && (r_level < LVLW'(NG)))
        w_level_next = r_level + 1'b1;
    end
    for (int k = 0; k < NG; k++) w_rcon_next[k] = rcon_bit(int'(w_level_next), k);
  end

  // LEVEL and ApproxRCON move on the same edge, so the adder configuration
  // never disagrees with the reported level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_level    <= '0;
      r_rcon     <= '1;
      r_err_acc  <= '0;
      r_win_done <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      r_level    <= w_level_next;
      r_rcon     <= w_rcon_next;
      r_win_done <= 1'b0;
      if (FORCE_EXACT) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == ST_DECIDE) begin
        r_err_acc  <= r_acc;
        r_win_done <= 1'b1;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign IN_READY   = w_ready;
  assign ApproxRCON = r_rcon;
  assign LEVEL      = r_level;
  assign ERR_ACC    = r_err_acc;
  assign WIN_DONE   = r_win_done;

endmodule

// File: tb/tb_sara_recon_ctrl.sv
// Self-checking bench for sara_recon_ctrl (SIZE=16, GROUPSIZE=8, WINDOW=4):
// directed and randomized windows scored against a window-level model.
module tb_sara_recon_ctrl;

  localparam int SIZE    = 16;
  localparam int GSIZE   = 8;
  localparam int WINDOW  = 4;
  localparam int NG      = 2;
  localparam int ACCW    = 19;
  localparam int ACC_MAX = (1 << ACCW) - 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic            IN_VALID;
  logic            IN_READY;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            CIN;
  logic [SIZE-1:0] SUM_APX;
  logic            COUT_APX;
  logic            ENABLE;
  logic            FORCE_EXACT;
  logic [ACCW-1:0] THRESH;
  logic [NG-1:0]   ApproxRCON;
  logic [1:0]      LEVEL;
  logic [ACCW-1:0] ERR_ACC;
  logic            WIN_DONE;

  int n_tests = 0;
  int n_fail  = 0;

  // Window-level reference state.
  int m_level   = 0;
  int m_acc     = 0;
  int m_cnt     = 0;
  int m_err_acc = 0;
  int m_thresh  = 64;
  bit m_en      = 1'b1;

  sara_recon_ctrl #(
    .SIZE      (SIZE),
    .GROUPSIZE (GSIZE),
    .WINDOW    (WINDOW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .A           (A),
    .B           (B),
    .CIN         (CIN),
    .SUM_APX     (SUM_APX),
    .COUT_APX    (COUT_APX),
    .ENABLE      (ENABLE),
    .FORCE_EXACT (FORCE_EXACT),
    .THRESH      (THRESH),
    .ApproxRCON  (ApproxRCON),
    .LEVEL       (LEVEL),
    .ERR_ACC     (ERR_ACC),
    .WIN_DONE    (WIN_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Group g (1-indexed) is exact when g > level.
  function automatic int exp_rcon(int lvl);
    int r = 0;
    for (int g = 1; g <= NG; g++) if (g > lvl) r = r | (1 << (g - 1));
    return r;
  endfunction

  // Called one cycle after the accepting edge of the last sample of a window.
  task automatic finish_window();
    int prev;
    check("decide_ready", 32'(IN_READY), 0);
    check("decide_no_pulse_yet", 32'(WIN_DONE), 0);
    prev = m_level;
    if (m_en && m_acc > m_thresh && m_level > 0) m_level--;
    else if (m_en && m_acc < m_thresh / 4 && m_level < NG) m_level++;
    m_err_acc = m_acc;
    m_acc = 0;
    m_cnt = 0;
    tick();
    check("win_done", 32'(WIN_DONE), 1);
    check("err_acc", 32'(ERR_ACC), 32'(m_err_acc));
    check("level", 32'(LEVEL), 32'(m_level));
    check("rcon", 32'(ApproxRCON), 32'(exp_rcon(m_level)));
    if (m_level != prev) begin
      check("settle_ready", 32'(IN_READY), 0);
      tick();
    end
    check("accum_ready", 32'(IN_READY), 1);
  endtask

  // Present one sample whose adder result is off from the exact sum by delta.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input int delta);
    int exact, apx, err;
    bit done;
    exact = int'(a) + int'(b) + int'(cin);
    apx   = (exact >= delta) ? exact - delta : exact + delta;
    err   = (exact >= apx) ? exact - apx : apx - exact;
    A = a; B = b; CIN = cin; SUM_APX = apx[15:0]; COUT_APX = apx[16];
    IN_VALID = 1'b1;
    #1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (IN_READY) done = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    if (!done) begin
      check("accept_timeout", 0, 1);
    end else begin
      m_acc = (m_acc + err > ACC_MAX) ? ACC_MAX : m_acc + err;
      m_cnt++;
      if (m_cnt == WINDOW) finish_window();
      else check("win_done_mid", 32'(WIN_DONE), 0);
    end
  endtask

  task automatic zero_window();
    for (int s = 0; s < WINDOW; s++) send(16'($urandom), 16'($urandom), 1'($urandom), 0);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0; SUM_APX = '0; COUT_APX = 1'b0;
    ENABLE = 1'b1; FORCE_EXACT = 1'b0; THRESH = 19'(m_thresh);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(IN_READY), 0);
    end
    check("rst_level", 32'(LEVEL), 0);
    check("rst_rcon", 32'(ApproxRCON), 32'h3);
    check("rst_err_acc", 32'(ERR_ACC), 0);
    check("rst_win_done", 32'(WIN_DONE), 0);
    RST = 1'b0;
    #1;
    check("post_rst_ready_c1", 32'(IN_READY), 0);
    tick();
    check("post_rst_ready_c2", 32'(IN_READY), 1);

    // Relax: exact results from level 0.
    zero_window();
    check("relax_level", 32'(LEVEL), 1);
    check("relax_rcon", 32'(ApproxRCON), 32'h2);

    // Tighten: error 256 per sample.
    for (int s = 0; s < WINDOW; s++) send(16'h00FF, 16'h0001, 1'b0, 256);
    check("tighten_err_acc", 32'(ERR_ACC), 1024);
    check("tighten_level", 32'(LEVEL), 0);

    // Climb to the ceiling, then one more zero-error window at the ceiling.
    zero_window();
    zero_window();
    zero_window();
    check("ceiling_level", 32'(LEVEL), 2);
    check("ceiling_rcon", 32'(ApproxRCON), 0);

    // Idle gaps inside a window do not disturb the count or the sum.
    for (int s = 0; s < WINDOW; s++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 5);
      repeat (3) tick();
    end

    // Randomized windows with mixed error sizes and occasional freeze.
    for (int w = 0; w < 8; w++) begin
      int cls;
      m_en = ($urandom_range(0, 3) != 0);
      ENABLE = m_en;
      cls = $urandom_range(0, 2);
      for (int s = 0; s < WINDOW; s++) begin
        int d;
        d = (cls == 0) ? 0 : (cls == 1) ? $urandom_range(0, 10) : $urandom_range(10, 60);
        send(16'($urandom), 16'($urandom), 1'($urandom), d);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    m_en = 1'b1;
    ENABLE = 1'b1;

    // FORCE_EXACT pulse two samples into a window at level 2.
    for (int w = 0; w < 3 && m_level < NG; w++) zero_window();
    check("force_pre_level", 32'(LEVEL), 2);
    send(16'($urandom), 16'($urandom), 1'b0, 0);
    send(16'($urandom), 16'($urandom), 1'b0, 0);
    FORCE_EXACT = 1'b1;
    IN_VALID = 1'b1;
    #1;
    check("force_ready", 32'(IN_READY), 0);
    tick();
    FORCE_EXACT = 1'b0;
    IN_VALID = 1'b0;
    m_level = 0; m_acc = 0; m_cnt = 0;
    check("force_level", 32'(LEVEL), 0);
    check("force_rcon", 32'(ApproxRCON), 32'h3);
    check("force_win_done", 32'(WIN_DONE), 0);
    check("force_err_acc_held", 32'(ERR_ACC), 32'(m_err_acc));
    #1;
    check("force_settle_ready", 32'(IN_READY), 0);
    tick();
    check("force_accum_ready", 32'(IN_READY), 1);
    zero_window();

    // Reset three samples into a window with IN_VALID held high.
    for (int s = 0; s < 3; s++) send(16'($urandom), 16'($urandom), 1'b0, 200);
    A = 16'h1234; B = 16'h0101; CIN = 1'b0; SUM_APX = 16'h1335; COUT_APX = 1'b0;
    IN_VALID = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_level = 0; m_acc = 0; m_cnt = 0; m_err_acc = 0;
    check("midrst_level", 32'(LEVEL), 0);
    check("midrst_err_acc", 32'(ERR_ACC), 0);
    #1;
    check("midrst_ready", 32'(IN_READY), 0);
    tick();
    zero_window();
    check("midrst_final_err_acc", 32'(ERR_ACC), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sara_recon_ctrl.md
SARA_RECON_CTRL -- requirements
Module: sara_recon_ctrl

Interface
REQ-001 The parameter SIZE SHALL default to 16 and set the operand width.
REQ-002 The parameter GROUPSIZE SHALL default to 8 and set the width of one SARA group; NG = SIZE/GROUPSIZE.
REQ-003 The parameter WINDOW SHALL default to 16 and set the number of accepted samples per evaluation window (power of two, ≥2).
REQ-004 The parameter ACCW SHALL default to SIZE+1+log2(WINDOW) and set the error accumulator width.
REQ-005 Port CLK SHALL be an input, 1 bit: the single clock, with all state on its rising edge.
REQ-006 Port RST SHALL be an input, 1 bit: synchronous active-high reset.
REQ-007 Port IN_VALID SHALL be an input, 1 bit: the sample on A/B/CIN/SUM_APX/COUT_APX is valid.
REQ-008 Port IN_READY SHALL be an output, 1 bit: the controller accepts a sample this cycle.
REQ-009 Port A, B SHALL be inputs, SIZE bits each: the operands currently driven into the SARA adder.
REQ-010 Port CIN SHALL be an input, 1 bit: the carry-in driven into the adder.
REQ-011 Port SUM_APX SHALL be an input, SIZE bits, and port COUT_APX an input, 1 bit: the adder's result.
REQ-012 Port ENABLE SHALL be an input, 1 bit: 0 freezes LEVEL, while windows still run.
REQ-013 Port FORCE_EXACT SHALL be an input, 1 bit: demands the fully exact configuration.
REQ-014 Port THRESH SHALL be an input, ACCW bits: the per-window error budget.
REQ-015 Port ApproxRCON SHALL be an output, NG bits, registered: it drives the adder's reconfiguration inputs, where bit=1 passes the exact group carry and bit=0 passes only the group generate.
REQ-016 Port LEVEL SHALL be an output, clog2(NG+1) bits: the current approximation level.
REQ-017 Port ERR_ACC SHALL be an output, ACCW bits: the total error of the last completed window.
REQ-018 Port WIN_DONE SHALL be an output, 1 bit: a one-cycle pulse when a window decision is made.

Function
REQ-019 For each level L, ApproxRCON[k] SHALL be 0 for k ≤ L and 1 for k > L (1-indexed); L=0 is fully exact, and the maximum level is NG.
REQ-020 A sample SHALL be accepted only on a cycle where IN_VALID and IN_READY are both 1.
REQ-021 Per accepted sample, the controller SHALL compute exact = A+B+CIN (SIZE+1 bits) and error = |exact − {COUT_APX,SUM_APX}|, then add error to a saturating window accumulator.
REQ-022 The FSM SHALL have the states ACCUM, DECIDE and SETTLE.
REQ-023 In ACCUM, IN_READY SHALL be 1; accepting the WINDOW-th sample SHALL transition to DECIDE.
REQ-024 In DECIDE, IN_READY SHALL be 0, and the following SHALL happen for one cycle:
- ERR_ACC ← accumulator; WIN_DONE=1; accumulator and sample count cleared.
- If ENABLE=1 and accumulator > THRESH and L>0: L ← L−1.
- Else if ENABLE=1 and accumulator < (THRESH>>2) and L<NG: L ← L+1.
- Otherwise L is held.
- Next state SETTLE if L changed, else ACCUM.
REQ-025 In SETTLE, IN_READY SHALL be 0 for one cycle so the adder sees the new ApproxRCON; the next state SHALL be ACCUM.
REQ-026 ApproxRCON SHALL update on the same edge as LEVEL, so every accepted sample is evaluated under a stable configuration.
REQ-027 FORCE_EXACT=1 SHALL take priority over all other events:
- Next edge: L ← 0, accumulator and count cleared, state ← SETTLE, WIN_DONE=0, ERR_ACC held.
- A sample presented on the same cycle is not accepted (IN_READY=0 while FORCE_EXACT=1).
REQ-028 The accumulator SHALL saturate at 2^ACCW−1 and never wrap.
REQ-029 When IN_VALID=0, the accumulator and count SHALL hold; windows have no timeout.

Reset
REQ-030 When RST=1 at an edge, the following SHALL take effect and override FORCE_EXACT:
- state ← SETTLE; LEVEL ← 0; ApproxRCON ← all ones.
- ERR_ACC ← 0; WIN_DONE ← 0; accumulator and count ← 0.
REQ-031 IN_READY SHALL be 0 while RST=1 and during the first cycle after RST is released, then 1.
REQ-032 Reset asserted mid-window SHALL discard all partial-window data.

Structure
REQ-033 The state encoding, the level-to-ApproxRCON mapping function and the ACCW/level-width computations SHALL live in the shared package sara_pkg.
REQ-034 The sub-module sara_err_calc (combinational exact add plus absolute difference) SHALL be instantiated once.
REQ-035 The implementation SHALL be 120–400 lines of RTL.

Verification (SIZE=16, GROUPSIZE=8, WINDOW=4, THRESH=64)
REQ-036 Reset: with RST held for 3 cycles, ApproxRCON=2'b11, LEVEL=0, ERR_ACC=0 and IN_READY=0 during reset and for 1 cycle after; IN_READY=1 on the second cycle.
REQ-037 Relax: from L=0, 4 samples with exact adder outputs give ERR_ACC=0 and a WIN_DONE pulse, then LEVEL=1 and ApproxRCON=2'b10 after DECIDE, with one SETTLE cycle at IN_READY=0.
REQ-038 Tighten: at L=1, 4 samples of A=16'h00FF, B=16'h0001, CIN=0, SUM_APX=16'h0000, COUT_APX=0 give error 256 each and ERR_ACC=1024; LEVEL then returns to 0.
REQ-039 Ceiling: at L=2, a window with zero error keeps LEVEL=2, ApproxRCON=2'b00, and no SETTLE cycle follows.
REQ-040 FORCE_EXACT pulse: a FORCE_EXACT pulse after 2 samples at L=2 gives LEVEL=0 and ApproxRCON=2'b11 next cycle; the next WIN_DONE fires only after 4 further samples.
REQ-041 Reset mid-window with IN_VALID held high: RST after 3 samples, then 4 zero-error samples, gives WIN_DONE exactly after the 4th post-reset sample with ERR_ACC=0.
